instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Instruction-fetch responder for the 8-bit CPU: the memory end of the PC/INSTRUCTION fetch interface.
- Accepts a fetch request carrying a 32-bit byte-address PC and returns the 32-bit instruction word after a fixed multi-cycle latency.
- Holds the CPU with BUSYWAIT while the fetch is in progress.
- Byte-wide load port lets the bench or boot logic program the store.

Parameters:
MEM_BYTES, 1024, instruction store size in bytes (multiple of 4, power of 2)
ADDR_W, 10, log2(MEM_BYTES); width of in-range byte address
READ_LATENCY, 4, cycles spent in WAIT before the response (>=1)
ERR_WORD, 32'hFFFF_FFFF, word returned on address error (opcode 0xFF decodes as no-write NOP)

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  asynchronous, active-low reset
PC  in  32  fetch byte address, sampled on request acceptance
READ  in  1  fetch request
INSTRUCTION  out  32  fetched word, valid while in RESP
BUSYWAIT  out  1  stall: CPU must hold PC and not advance
ADDR_ERR  out  1  fetch address out of range or misaligned, valid while in RESP
LOAD_EN  in  1  byte write strobe for programming
LOAD_ADDR  in  ADDR_W  byte address for the load
LOAD_DATA  in  8  byte to write

Behaviour:
- Storage: MEM_BYTES x 8 array, little-endian. Word at byte address a = {mem[a+3],mem[a+2],mem[a+1],mem[a]}. Contents are not cleared by reset.
- Reset (RESET=0, async):
  - state=IDLE, INSTRUCTION=0, ADDR_ERR=0, BUSYWAIT=0, counter=0.
  - An in-flight fetch is aborted with no response.
  - LOAD_EN is ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a posedge with READ=1:
  - latch addr_q=PC
  - cnt=READ_LATENCY-1
  - go to WAIT.
  - With READ=0, stay in IDLE.
- WAIT: on each posedge:
  - If cnt==0: register the response and go to RESP.
  - Otherwise decrement cnt.
  - PC and READ changes during WAIT are ignored; the latched address is used and the fetch always completes.
- Response word:
  - If addr_q[31:ADDR_W]!=0 or addr_q[1:0]!=0: INSTRUCTION=ERR_WORD and ADDR_ERR=1.
  - Otherwise: INSTRUCTION=word(addr_q) and ADDR_ERR=0.
- RESP: lasts exactly 1 cycle, then goes to IDLE. INSTRUCTION and ADDR_ERR hold their values until the next response or reset.
- BUSYWAIT (combinational): (state==IDLE && READ) || state==WAIT. It is low in RESP; the CPU samples INSTRUCTION at the posedge ending RESP.
- Latency: request accepted at edge E0. BUSYWAIT is high from the cycle READ rises through READ_LATENCY further cycles. RESP is the cycle after edge E0+READ_LATENCY.
- Back-to-back fetches: READ held high in RESP is not accepted in RESP. The next acceptance is at the first IDLE edge, so the minimum request period is READ_LATENCY+2 cycles.
- Load port:
  - Any state except reset: on posedge with LOAD_EN=1, mem[LOAD_ADDR]=LOAD_DATA.
  - If a load hits a byte of the word being captured on the WAIT->RESP edge, the response carries the old byte (read-before-write).
  - Loads never affect FSM state or BUSYWAIT.

Test Plan:
- Program bytes 0..7 = 02 01 03 04 / 78 56 34 12 via load port; READ=1, PC=4, READ_LATENCY=4 -> BUSYWAIT high 5 cycles, then RESP with INSTRUCTION=32'h1234_5678, ADDR_ERR=0; next cycle IDLE.
- PC=32'h0000_0400 (==MEM_BYTES) and PC=32'h0000_0006 (misaligned) -> each returns INSTRUCTION=32'hFFFF_FFFF, ADDR_ERR=1 after the same latency.
- Accept fetch at PC=0, change PC to 4 and drop READ during WAIT -> response still word(0); BUSYWAIT held through WAIT regardless of READ.
- Assert RESET low two cycles into WAIT -> BUSYWAIT and INSTRUCTION go to 0 immediately; no RESP. After release, memory still holds programmed bytes (fetch PC=4 returns 32'h1234_5678).
- Fetch PC=4 with LOAD_EN writing LOAD_ADDR=4, LOAD_DATA=8'hAA on the WAIT->RESP edge -> response 32'h1234_5678; a second fetch returns 32'h1234_56AA.
- READ held high continuously, PC=0 -> responses spaced exactly READ_LATENCY+2 = 6 cycles apart; BUSYWAIT low only in RESP cycles.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: byte-addressed little-endian store with a
// fixed-latency word fetch, a BUSYWAIT stall output and a byte load port.
//
// Ports:
//   CLK         clock, all state updates on posedge
//   RESET       asynchronous active-low reset
//   PC          fetch byte address, latched when a request is accepted
//   READ        fetch request
//   INSTRUCTION fetched word, valid in RESP and held until next response
//   BUSYWAIT    stall: high while a request is pending or in flight
//   ADDR_ERR    fetch address out of range or misaligned
//   LOAD_EN     byte write strobe for programming the store
//   LOAD_ADDR   byte address for the load
//   LOAD_DATA   byte to write
module instr_mem_responder #(
    parameter int          MEM_BYTES    = 1024,
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 4,
    parameter logic [31:0] ERR_WORD     = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    input  logic              READ,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              ADDR_ERR,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_DATA
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_instr;
    logic             r_err;
    logic [7:0]       r_mem [MEM_BYTES];

    logic [31:0]       w_word;
    logic              w_bad;
    logic [ADDR_W-1:0] w_base;

    // Word-aligned base of the latched address; only meaningful when
    // w_bad is low, otherwise the read result is discarded.
    always_comb begin
        w_base = {r_addr[ADDR_W-1:2], 2'b00};
        w_word = {r_mem[w_base | ADDR_W'(3)],
                  r_mem[w_base | ADDR_W'(2)],
                  r_mem[w_base | ADDR_W'(1)],
                  r_mem[w_base]};
        w_bad  = (r_addr[31:ADDR_W] != '0) || (r_addr[1:0] != 2'b00);
    end

    // Store is not reset; loads are only blocked while reset is held.
    // The capture below reads the pre-edge contents, so a load landing on
    // the capture edge is seen only by later fetches.
    always_ff @(posedge CLK) begin
        if (LOAD_EN && RESET) begin
            r_mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_instr <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (READ) begin
                        r_addr  <= PC;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_instr <= w_bad ? ERR_WORD : w_word;
                        r_err   <= w_bad;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is gated by reset so a held READ cannot raise it mid-reset.
    assign BUSYWAIT    = RESET &&
                         (((r_state == S_IDLE) && READ) ||
                          (r_state == S_WAIT));
    assign INSTRUCTION = r_instr;
    assign ADDR_ERR    = r_err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: latency, address errors,
// reset abort, load-during-capture and back-to-back fetch spacing.
module tb_instr_mem_responder;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic        READ;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        ADDR_ERR;
    logic        LOAD_EN;
    logic [9:0]  LOAD_ADDR;
    logic [7:0]  LOAD_DATA;

    int vec_cnt;
    int err_cnt;

    instr_mem_responder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC         (PC),
        .READ       (READ),
        .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT   (BUSYWAIT),
        .ADDR_ERR   (ADDR_ERR),
        .LOAD_EN    (LOAD_EN),
        .LOAD_ADDR  (LOAD_ADDR),
        .LOAD_DATA  (LOAD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [7:0] d);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = a;
        LOAD_DATA = d;
        step();
        LOAD_EN   = 1'b0;
    endtask

    // Issue one fetch from IDLE, drop READ after acceptance, optionally
    // move PC during WAIT and load 0xAA at byte 4 on the capture edge.
    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic [31:0] pc_wait, input bit do_ld,
                         input logic [31:0] exp_w, input logic exp_e);
        int n;
        PC   = pc;
        READ = 1'b1;
        #1;
        chk({tag, "_busy0"}, {31'b0, BUSYWAIT}, 32'd1);
        n = 0;
        while (BUSYWAIT && n < 20) begin
            n++;
            step();
            READ      = 1'b0;
            PC        = pc_wait;
            LOAD_EN   = do_ld && (n == 4);
            LOAD_ADDR = 10'd4;
            LOAD_DATA = 8'hAA;
            #1;
        end
        LOAD_EN = 1'b0;
        chk({tag, "_busycyc"}, n, 32'd5);
        chk({tag, "_instr"}, INSTRUCTION, exp_w);
        chk({tag, "_err"}, {31'b0, ADDR_ERR}, {31'b0, exp_e});
        step();
        chk({tag, "_idle_busy"}, {31'b0, BUSYWAIT}, 32'd0);
        chk({tag, "_hold"}, INSTRUCTION, exp_w);
    endtask

    initial begin
        int n;
        vec_cnt   = 0;
        err_cnt   = 0;
        RESET     = 1'b0;
        PC        = '0;
        READ      = 1'b0;
        LOAD_EN   = 1'b0;
        LOAD_ADDR = '0;
        LOAD_DATA = '0;
        step();
        step();
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_err", {31'b0, ADDR_ERR}, 32'd0);
        chk("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        RESET = 1'b1;
        step();

        load(10'd0, 8'h02);
        load(10'd1, 8'h01);
        load(10'd2, 8'h03);
        load(10'd3, 8'h04);
        load(10'd4, 8'h78);
        load(10'd5, 8'h56);
        load(10'd6, 8'h34);
        load(10'd7, 8'h12);

        fetch("pc4", 32'h4, 32'h4, 1'b0, 32'h1234_5678, 1'b0);
        fetch("oor", 32'h400, 32'h400, 1'b0, 32'hFFFF_FFFF, 1'b1);
        fetch("mis", 32'h6, 32'h6, 1'b0, 32'hFFFF_FFFF, 1'b1);
        fetch("hi", 32'h8000_0000, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        fetch("pcmove", 32'h0, 32'h4, 1'b0, 32'h0403_0102, 1'b0);

        // Abort: reset two cycles into WAIT, load attempted under reset.
        PC   = 32'h4;
        READ = 1'b1;
        step();
        READ = 1'b0;
        step();
        step();
        chk("abort_pre_busy", {31'b0, BUSYWAIT}, 32'd1);
        RESET     = 1'b0;
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 10'd5;
        LOAD_DATA = 8'h55;
        #1;
        chk("abort_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("abort_instr", INSTRUCTION, 32'h0);
        step();
        step();
        step();
        LOAD_EN = 1'b0;
        chk("abort_noresp", INSTRUCTION, 32'h0);
        RESET = 1'b1;
        step();
        chk("abort_idle", {31'b0, BUSYWAIT}, 32'd0);
        fetch("postrst", 32'h4, 32'h4, 1'b0, 32'h1234_5678, 1'b0);

        fetch("ldcap", 32'h4, 32'h4, 1'b1, 32'h1234_5678, 1'b0);
        fetch("ldnew", 32'h4, 32'h4, 1'b0, 32'h1234_56AA, 1'b0);

        // Back-to-back: READ held; RESP cycles fall at k = 4, 10, 16.
        PC   = 32'h0;
        READ = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            chk($sformatf("b2b_busy%0d", k), {31'b0, BUSYWAIT},
                (k % 6 == 4) ? 32'd0 : 32'd1);
            if (k % 6 == 4) begin
                chk($sformatf("b2b_instr%0d", k), INSTRUCTION,
                    32'h0403_0102);
            end
        end
        READ = 1'b0;
        n = 0;
        #1;
        while (BUSYWAIT && n < 20) begin
            n++;
            step();
        end
        chk("drain", {31'b0, BUSYWAIT}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
